// File: rtl/load_store_queue.sv
// rtl/load_store_queue.sv - in-order load/store queue between dispatch, result buses and memory
// Define LSQ_SPEC_LOAD_EN to let non-IO head loads issue before commit.
module load_store_queue #(
  parameter int          DEPTH   = 16,
  parameter int          IDX_W   = 4,
  parameter int          ROB_W   = 5,
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             dispatch_valid,
  input  logic [6:0]       dispatch_op,
  input  logic [31:0]      dispatch_imm,
  input  logic [ROB_W-1:0] dispatch_rd,
  input  logic [ROB_W-1:0] dispatch_Qi,
  input  logic [ROB_W-1:0] dispatch_Qj,
  input  logic [31:0]      dispatch_Vi,
  input  logic [31:0]      dispatch_Vj,
  output logic             lsq_full,
  input  logic             alu_valid,
  input  logic [ROB_W-1:0] alu_rob_id,
  input  logic [31:0]      alu_res,
  input  logic             rob_valid,
  input  logic [ROB_W-1:0] rob_commit_id,
  output logic             mem_req,
  output logic             mem_is_load,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [6:0]       mem_op,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata,
  output logic             lsq_valid,
  output logic [ROB_W-1:0] lsq_rob_id,
  output logic [31:0]      lsq_res
);

  // Opcode encoding: LB, LH, LW, LBU, LHU = 10..14; SB, SH, SW = 15..17.
  localparam logic [6:0]     OP_LB    = 7'd10;
  localparam logic [6:0]     OP_LHU   = 7'd14;
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);

`ifdef LSQ_SPEC_LOAD_EN
  localparam bit SPEC_LOAD = 1'b1;
`else
  localparam bit SPEC_LOAD = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  logic             valid_q [DEPTH];
  logic             valid_d [DEPTH];
  logic [6:0]       op_q    [DEPTH];
  logic [6:0]       op_d    [DEPTH];
  logic [31:0]      imm_q   [DEPTH];
  logic [31:0]      imm_d   [DEPTH];
  logic [ROB_W-1:0] rd_q    [DEPTH];
  logic [ROB_W-1:0] rd_d    [DEPTH];
  logic [ROB_W-1:0] qi_q    [DEPTH];
  logic [ROB_W-1:0] qi_d    [DEPTH];
  logic [ROB_W-1:0] qj_q    [DEPTH];
  logic [ROB_W-1:0] qj_d    [DEPTH];
  logic [31:0]      vi_q    [DEPTH];
  logic [31:0]      vi_d    [DEPTH];
  logic [31:0]      vj_q    [DEPTH];
  logic [31:0]      vj_d    [DEPTH];

  logic             mem_req_q, mem_req_d, mem_is_load_q, mem_is_load_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [6:0]       mem_op_q, mem_op_d;
  logic             lsq_valid_q, lsq_valid_d;
  logic [ROB_W-1:0] lsq_rob_id_q, lsq_rob_id_d, cur_rd_q, cur_rd_d;
  logic [31:0]      lsq_res_q, lsq_res_d;
  logic             squash_q, squash_d;

  logic             head_is_load, head_is_io, head_ready, head_commit, can_issue;
  logic [31:0]      head_addr;
  logic             enq, deq;

  assign lsq_full     = (count_q == FULL_CNT);
  assign head_is_load = (op_q[head_q] >= OP_LB) && (op_q[head_q] <= OP_LHU);
  assign head_addr    = vi_q[head_q] + imm_q[head_q];
  assign head_is_io   = (head_addr >= IO_BASE);
  assign head_ready   = valid_q[head_q] && (qi_q[head_q] == '0) &&
                        (head_is_load || (qj_q[head_q] == '0));
  assign head_commit  = rob_valid && (rob_commit_id == rd_q[head_q]);
  assign can_issue    = head_ready &&
                        (head_commit || (SPEC_LOAD && head_is_load && !head_is_io));

  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    valid_d       = valid_q;
    op_d          = op_q;
    imm_d         = imm_q;
    rd_d          = rd_q;
    qi_d          = qi_q;
    qj_d          = qj_q;
    vi_d          = vi_q;
    vj_d          = vj_q;
    mem_req_d     = mem_req_q;
    mem_is_load_d = mem_is_load_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_op_d      = mem_op_q;
    cur_rd_d      = cur_rd_q;
    squash_d      = squash_q;
    lsq_valid_d   = 1'b0;
    lsq_rob_id_d  = '0;
    lsq_res_d     = '0;
    enq           = 1'b0;
    deq           = 1'b0;

    // Tag 0 means "no dependency" and must never be woken by a bus.
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (qi_q[i] != '0)) begin
        if (alu_valid && (qi_q[i] == alu_rob_id)) begin
          qi_d[i] = '0;
          vi_d[i] = alu_res;
        end else if (lsq_valid_q && (qi_q[i] == lsq_rob_id_q)) begin
          qi_d[i] = '0;
          vi_d[i] = lsq_res_q;
        end
      end
      if (valid_q[i] && (qj_q[i] != '0)) begin
        if (alu_valid && (qj_q[i] == alu_rob_id)) begin
          qj_d[i] = '0;
          vj_d[i] = alu_res;
        end else if (lsq_valid_q && (qj_q[i] == lsq_rob_id_q)) begin
          qj_d[i] = '0;
          vj_d[i] = lsq_res_q;
        end
      end
    end

    if ((state_q == IDLE) && can_issue && !flush) begin
      deq             = 1'b1;
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
      mem_req_d       = 1'b1;
      mem_is_load_d   = head_is_load;
      mem_addr_d      = head_addr;
      mem_wdata_d     = vj_q[head_q];
      mem_op_d        = op_q[head_q];
      cur_rd_d        = rd_q[head_q];
      state_d         = head_is_load ? LOAD : STORE;
    end

    if (dispatch_valid && !lsq_full && !flush) begin
      enq             = 1'b1;
      valid_d[tail_q] = 1'b1;
      op_d[tail_q]    = dispatch_op;
      imm_d[tail_q]   = dispatch_imm;
      rd_d[tail_q]    = dispatch_rd;
      qi_d[tail_q]    = dispatch_Qi;
      vi_d[tail_q]    = dispatch_Vi;
      qj_d[tail_q]    = dispatch_Qj;
      vj_d[tail_q]    = dispatch_Vj;
      if ((dispatch_Qi != '0) && alu_valid && (dispatch_Qi == alu_rob_id)) begin
        qi_d[tail_q] = '0;
        vi_d[tail_q] = alu_res;
      end else if ((dispatch_Qi != '0) && lsq_valid_q && (dispatch_Qi == lsq_rob_id_q)) begin
        qi_d[tail_q] = '0;
        vi_d[tail_q] = lsq_res_q;
      end
      if ((dispatch_Qj != '0) && alu_valid && (dispatch_Qj == alu_rob_id)) begin
        qj_d[tail_q] = '0;
        vj_d[tail_q] = alu_res;
      end else if ((dispatch_Qj != '0) && lsq_valid_q && (dispatch_Qj == lsq_rob_id_q)) begin
        qj_d[tail_q] = '0;
        vj_d[tail_q] = lsq_res_q;
      end
      tail_d = tail_q + 1'b1;
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      LOAD: begin
        if (mem_done) begin
          mem_req_d    = 1'b0;
          state_d      = IDLE;
          lsq_valid_d  = 1'b1;
          lsq_rob_id_d = cur_rd_q;
          lsq_res_d    = mem_rdata;
        end
      end
      STORE: begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          squash_d  = 1'b0;
          if (!squash_q) begin
            lsq_valid_d  = 1'b1;
            lsq_rob_id_d = cur_rd_q;
          end
        end
      end
      default: ;
    endcase

    // A committed store must still finish on the bus; only its broadcast is dropped.
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) valid_d[i] = 1'b0;
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      lsq_valid_d  = 1'b0;
      lsq_rob_id_d = '0;
      lsq_res_d    = '0;
      if (state_q == STORE) begin
        if (!mem_done) squash_d = 1'b1;
      end else begin
        state_d       = IDLE;
        mem_req_d     = 1'b0;
        mem_is_load_d = 1'b0;
        mem_addr_d    = '0;
        mem_wdata_d   = '0;
        mem_op_d      = '0;
        cur_rd_d      = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_is_load_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_op_q      <= '0;
      cur_rd_q      <= '0;
      squash_q      <= 1'b0;
      lsq_valid_q   <= 1'b0;
      lsq_rob_id_q  <= '0;
      lsq_res_q     <= '0;
    end else if (rdy) begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      valid_q       <= valid_d;
      op_q          <= op_d;
      imm_q         <= imm_d;
      rd_q          <= rd_d;
      qi_q          <= qi_d;
      qj_q          <= qj_d;
      vi_q          <= vi_d;
      vj_q          <= vj_d;
      mem_req_q     <= mem_req_d;
      mem_is_load_q <= mem_is_load_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_op_q      <= mem_op_d;
      cur_rd_q      <= cur_rd_d;
      squash_q      <= squash_d;
      lsq_valid_q   <= lsq_valid_d;
      lsq_rob_id_q  <= lsq_rob_id_d;
      lsq_res_q     <= lsq_res_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_is_load = mem_is_load_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_op      = mem_op_q;
  assign lsq_valid   = lsq_valid_q;
  assign lsq_rob_id  = lsq_rob_id_q;
  assign lsq_res     = lsq_res_q;

endmodule

// File: tb/tb_load_store_queue.sv
// tb/tb_load_store_queue.sv - directed self-checking bench for load_store_queue
module tb_load_store_queue;

  localparam logic [6:0] OP_LB = 7'd10;
  localparam logic [6:0] OP_LW = 7'd12;
  localparam logic [6:0] OP_SW = 7'd17;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        dispatch_valid;
  logic [6:0]  dispatch_op;
  logic [31:0] dispatch_imm, dispatch_Vi, dispatch_Vj;
  logic [4:0]  dispatch_rd, dispatch_Qi, dispatch_Qj;
  logic        lsq_full;
  logic        alu_valid;
  logic [4:0]  alu_rob_id;
  logic [31:0] alu_res;
  logic        rob_valid;
  logic [4:0]  rob_commit_id;
  logic        mem_req, mem_is_load;
  logic [31:0] mem_addr, mem_wdata;
  logic [6:0]  mem_op;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        lsq_valid;
  logic [4:0]  lsq_rob_id;
  logic [31:0] lsq_res;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
    .dispatch_imm(dispatch_imm), .dispatch_rd(dispatch_rd),
    .dispatch_Qi(dispatch_Qi), .dispatch_Qj(dispatch_Qj),
    .dispatch_Vi(dispatch_Vi), .dispatch_Vj(dispatch_Vj),
    .lsq_full(lsq_full),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_res(alu_res),
    .rob_valid(rob_valid), .rob_commit_id(rob_commit_id),
    .mem_req(mem_req), .mem_is_load(mem_is_load), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_op(mem_op),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .lsq_valid(lsq_valid), .lsq_rob_id(lsq_rob_id), .lsq_res(lsq_res)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] qi,
                      input logic [31:0] vi, input logic [31:0] imm,
                      input logic [4:0] qj, input logic [31:0] vj);
    dispatch_valid = 1'b1;
    dispatch_op    = op;
    dispatch_rd    = rd;
    dispatch_Qi    = qi;
    dispatch_Vi    = vi;
    dispatch_imm   = imm;
    dispatch_Qj    = qj;
    dispatch_Vj    = vj;
  endtask

  task automatic commit(input logic [4:0] id);
    rob_valid     = 1'b1;
    rob_commit_id = id;
    tick();
    rob_valid     = 1'b0;
  endtask

  task automatic done(input logic [31:0] rdata);
    mem_done  = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_done  = 1'b0;
  endtask

  function automatic logic [4:0] rd2(input int j);
    return (j < 15) ? 5'(17 + j) : 5'd1;
  endfunction

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    dispatch_valid = 1'b0; dispatch_op = '0; dispatch_imm = '0; dispatch_rd = '0;
    dispatch_Qi = '0; dispatch_Qj = '0; dispatch_Vi = '0; dispatch_Vj = '0;
    alu_valid = 1'b0; alu_rob_id = '0; alu_res = '0;
    rob_valid = 1'b0; rob_commit_id = '0; mem_done = 1'b0; mem_rdata = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_lsq_valid", lsq_valid, 0);
    chk("rst_full", lsq_full, 0);
    chk("rst_addr", mem_addr, 0);

    // Basic load with commit
    disp(OP_LW, 5'd3, 5'd0, 32'h100, 32'd4, 5'd0, 32'd0); tick(); dispatch_valid = 1'b0;
    commit(5'd3);
    chk("t1_req", mem_req, 1);
    chk("t1_addr", mem_addr, 32'h104);
    chk("t1_is_load", mem_is_load, 1);
    chk("t1_op", mem_op, OP_LW);
    tick();
    chk("t1_hold_req", mem_req, 1);
    chk("t1_hold_addr", mem_addr, 32'h104);
    chk("t1_no_early_result", lsq_valid, 0);
    done(32'hDEADBEEF);
    chk("t1_valid", lsq_valid, 1);
    chk("t1_id", lsq_rob_id, 3);
    chk("t1_res", lsq_res, 32'hDEADBEEF);
    chk("t1_req_drop", mem_req, 0);
    tick();
    chk("t1_pulse_end", lsq_valid, 0);

    // Store whose data arrives via ALU snoop
    disp(OP_SW, 5'd5, 5'd0, 32'h200, 32'd8, 5'd7, 32'd0); tick(); dispatch_valid = 1'b0;
    alu_valid = 1'b1; alu_rob_id = 5'd7; alu_res = 32'h55; tick(); alu_valid = 1'b0;
    commit(5'd5);
    chk("t2_req", mem_req, 1);
    chk("t2_is_load", mem_is_load, 0);
    chk("t2_wdata", mem_wdata, 32'h55);
    chk("t2_addr", mem_addr, 32'h208);
    done(32'h0);
    chk("t2_valid", lsq_valid, 1);
    chk("t2_id", lsq_rob_id, 5);
    chk("t2_res", lsq_res, 0);

    // Dispatch-time bypass from the LSQ bus (tag 5 is on it this cycle)
    disp(OP_SW, 5'd7, 5'd0, 32'h600, 32'd0, 5'd5, 32'hEEEE); tick(); dispatch_valid = 1'b0;
    commit(5'd7);
    chk("t3b_req", mem_req, 1);
    chk("t3b_wdata", mem_wdata, 32'h0);
    done(32'h0);
    chk("t3b_id", lsq_rob_id, 7);

    // ALU bypass wins over LSQ bus carrying the same tag
    disp(OP_LW, 5'd6, 5'd7, 32'hFFFF_0000, 32'h10, 5'd0, 32'd0);
    alu_valid = 1'b1; alu_rob_id = 5'd7; alu_res = 32'h200;
    tick(); dispatch_valid = 1'b0; alu_valid = 1'b0;
    commit(5'd6);
    chk("t3a_req", mem_req, 1);
    chk("t3a_addr", mem_addr, 32'h210);
    done(32'h11);
    chk("t3a_id", lsq_rob_id, 6);
    chk("t3a_res", lsq_res, 32'h11);

    // Tag 0 on the bus must not disturb ready operands
    disp(OP_SW, 5'd8, 5'd0, 32'h300, 32'd0, 5'd0, 32'hAAAA);
    alu_valid = 1'b1; alu_rob_id = 5'd0; alu_res = 32'h999;
    tick(); dispatch_valid = 1'b0; alu_res = 32'h777;
    tick(); alu_valid = 1'b0;
    commit(5'd8);
    chk("t3c_wdata", mem_wdata, 32'hAAAA);
    chk("t3c_addr", mem_addr, 32'h300);
    done(32'h0);
    chk("t3c_id", lsq_rob_id, 8);

    // Tag 0 on the bus must not wake a pending dependency
    disp(OP_SW, 5'd9, 5'd0, 32'h340, 32'd0, 5'd10, 32'd0); tick(); dispatch_valid = 1'b0;
    alu_valid = 1'b1; alu_rob_id = 5'd0; alu_res = 32'h5; tick(); alu_valid = 1'b0;
    commit(5'd9);
    chk("t3d_blocked", mem_req, 0);
    alu_valid = 1'b1; alu_rob_id = 5'd10; alu_res = 32'h1234; tick(); alu_valid = 1'b0;
    commit(5'd9);
    chk("t3d_req", mem_req, 1);
    chk("t3d_wdata", mem_wdata, 32'h1234);
    done(32'h0);
    chk("t3d_id", lsq_rob_id, 9);

    // Fill to DEPTH across the pointer wrap, then a dropped 17th dispatch
    for (int i = 0; i < 16; i++) begin
      disp(OP_SW, 5'(i + 1), 5'd0, 32'h1000, 32'(i * 4), 5'd0, 32'h100 + 32'(i));
      tick();
    end
    dispatch_valid = 1'b0;
    chk("t4_full", lsq_full, 1);
    disp(OP_SW, 5'd20, 5'd0, 32'h9000, 32'd0, 5'd0, 32'hBAD); tick(); dispatch_valid = 1'b0;
    chk("t4_full_after_drop", lsq_full, 1);

    // Pop first batch, enqueueing second batch on each later issue cycle
    for (int k = 0; k < 16; k++) begin
      if (k > 0) disp(OP_SW, rd2(k - 1), 5'd0, 32'h2000, 32'((k - 1) * 4), 5'd0, 32'h200 + 32'(k - 1));
      commit(5'(k + 1));
      dispatch_valid = 1'b0;
      chk($sformatf("t4_wdata_%0d", k), mem_wdata, 32'h100 + 32'(k));
      chk($sformatf("t4_addr_%0d", k), mem_addr, 32'h1000 + 32'(k * 4));
      done(32'h0);
      chk($sformatf("t4_id_%0d", k), lsq_rob_id, 32'(k + 1));
    end
    chk("t4_not_full", lsq_full, 0);
    disp(OP_SW, rd2(15), 5'd0, 32'h2000, 32'd60, 5'd0, 32'h20F); tick(); dispatch_valid = 1'b0;
    chk("t4_refull", lsq_full, 1);
    for (int j = 0; j < 16; j++) begin
      commit(rd2(j));
      chk($sformatf("t4b_wdata_%0d", j), mem_wdata, 32'h200 + 32'(j));
      done(32'h0);
      chk($sformatf("t4b_id_%0d", j), lsq_rob_id, 32'(rd2(j)));
    end
    chk("t4_empty", lsq_full, 0);

    // Flush during STORE: request held to completion, no broadcast, queue cleared
    disp(OP_SW, 5'd12, 5'd0, 32'h400, 32'd0, 5'd0, 32'h77); tick();
    disp(OP_SW, 5'd13, 5'd0, 32'h440, 32'd0, 5'd0, 32'h88); tick(); dispatch_valid = 1'b0;
    commit(5'd12);
    chk("t5_req", mem_req, 1);
    flush = 1'b1;
    disp(OP_SW, 5'd14, 5'd0, 32'h480, 32'd0, 5'd0, 32'h99);
    tick(); flush = 1'b0; dispatch_valid = 1'b0;
    chk("t5_req_held", mem_req, 1);
    chk("t5_addr_held", mem_addr, 32'h400);
    tick();
    chk("t5_req_held2", mem_req, 1);
    done(32'h0);
    chk("t5_req_drop", mem_req, 0);
    chk("t5_no_bcast", lsq_valid, 0);
    commit(5'd13);
    chk("t5_flushed_13", mem_req, 0);
    commit(5'd14);
    chk("t5_flushed_14", mem_req, 0);

    // Flush during LOAD: request drops next cycle, no broadcast
    disp(OP_LW, 5'd15, 5'd0, 32'h500, 32'd0, 5'd0, 32'd0); tick(); dispatch_valid = 1'b0;
    commit(5'd15);
    chk("t6_req", mem_req, 1);
    chk("t6_is_load", mem_is_load, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t6_req_drop", mem_req, 0);
    chk("t6_no_bcast", lsq_valid, 0);
    done(32'h99);
    chk("t6_stale_done", lsq_valid, 0);

    // rdy low freezes the queue, so this dispatch never lands
    rdy = 1'b0;
    disp(OP_SW, 5'd20, 5'd0, 32'h700, 32'd0, 5'd0, 32'h1); tick(); tick();
    dispatch_valid = 1'b0; rdy = 1'b1;
    commit(5'd20);
    chk("t7_rdy_hold", mem_req, 0);

`ifdef LSQ_SPEC_LOAD_EN
    disp(OP_LB, 5'd21, 5'd0, 32'h1000, 32'd0, 5'd0, 32'd0); tick(); dispatch_valid = 1'b0;
    tick();
    chk("t8_spec_req", mem_req, 1);
    chk("t8_spec_addr", mem_addr, 32'h1000);
    done(32'h42);
    chk("t8_spec_id", lsq_rob_id, 21);
    chk("t8_spec_res", lsq_res, 32'h42);
    disp(OP_LB, 5'd22, 5'd0, 32'h30000, 32'd0, 5'd0, 32'd0); tick(); dispatch_valid = 1'b0;
    tick(); tick();
    chk("t8_io_wait", mem_req, 0);
    commit(5'd22);
    chk("t8_io_req", mem_req, 1);
    chk("t8_io_addr", mem_addr, 32'h30000);
    done(32'h7);
    chk("t8_io_id", lsq_rob_id, 22);
`else
    disp(OP_LB, 5'd21, 5'd0, 32'h1000, 32'd0, 5'd0, 32'd0); tick(); dispatch_valid = 1'b0;
    tick(); tick();
    chk("t8_wait_commit", mem_req, 0);
    commit(5'd21);
    chk("t8_req", mem_req, 1);
    chk("t8_addr", mem_addr, 32'h1000);
    done(32'h42);
    chk("t8_id", lsq_rob_id, 21);
    chk("t8_res", lsq_res, 32'h42);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
